buf_load_sequencer: RTL

Writer-side engine for the banked activation/weight buffer write ports: the one-word-per-cycle address, one-hot bank-enable and data interface of the A/W buffers.
- Accepts a valid/ready stream of 32-bit words from the host/DMA side.
- Scatters words across banks and consecutive addresses, in the order the systolic feed expects.
- Sits between the external bus bridge and the A_buffer/W_buffer write ports; the system controller FSM starts it and waits for its done pulse.

---
 rtl/buf_load_sequencer_pkg.sv | 24 ++
 rtl/buf_load_sequencer_addr_counter.sv | 53 +++++
 rtl/buf_load_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/buf_load_sequencer_pkg.sv
// Shared definitions for the buffer write-path sequencers: FSM encoding,
// default geometry and the bank one-hot helper.
package buf_load_sequencer_pkg;

  localparam int unsigned NUM_BANKS_DEF = 16;
  localparam int unsigned RAM_SIZE_DEF  = 1024;
  localparam int unsigned ONEHOT_W      = 64;
  localparam int unsigned OH_IDX_W      = $clog2(ONEHOT_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Callers cast the result down to their own bank count.
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [OH_IDX_W-1:0] idx);
    logic [ONEHOT_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/buf_load_sequencer_addr_counter.sv
// Bank/word counter pair: bank-major walk over the configured rectangle,
// with a flag marking the final beat.
module load_addr_counter #(
  parameter int unsigned BANK_W = 5,
  parameter int unsigned CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [BANK_W-1:0] banks_i,
  input  logic [CNT_W-1:0]  words_i,
  output logic [BANK_W-1:0] bank_o,
  output logic [CNT_W-1:0]  word_o,
  output logic              last_o
);

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [CNT_W-1:0]  word_q, word_d;
  logic              bank_wrap;

  assign bank_wrap = (bank_q == banks_i - BANK_W'(1));
  assign last_o    = bank_wrap && (word_q == words_i - CNT_W'(1));
  assign bank_o    = bank_q;
  assign word_o    = word_q;

  always_comb begin
    bank_d = bank_q;
    word_d = word_q;
    if (clr_i) begin
      bank_d = '0;
      word_d = '0;
    end else if (adv_i) begin
      if (bank_wrap) begin
        bank_d = '0;
        word_d = word_q + CNT_W'(1);
      end else begin
        bank_d = bank_q + BANK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q <= '0;
      word_q <= '0;
    end else begin
      bank_q <= bank_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/buf_load_sequencer.sv
// Writer-side engine for the banked A/W buffers: scatters a valid/ready word
// stream across banks and consecutive addresses with registered write outputs.
module buf_load_sequencer
  import buf_load_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = NUM_BANKS_DEF,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_SIZE   = RAM_SIZE_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned BANK_W     = $clog2(NUM_BANKS) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [BANK_W-1:0]     num_banks,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [NUM_BANKS-1:0]  ram_w_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [BANK_W-1:0]     banks_q, banks_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic [NUM_BANKS-1:0]  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic              cnt_clr;
  logic              accept;
  logic              cfg_bad;
  logic              last_beat;
  logic [BANK_W-1:0] bank_cnt;
  logic [CNT_W-1:0]  word_cnt;

  assign s_ready = (state_q == LOAD) && !abort;
  assign accept  = s_valid && s_ready;
  assign cfg_bad = (num_banks == '0) || (num_banks > BANK_W'(NUM_BANKS)) || (num_words == '0);

  load_addr_counter #(
    .BANK_W (BANK_W),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .adv_i   (accept),
    .banks_i (banks_q),
    .words_i (words_q),
    .bank_o  (bank_cnt),
    .word_o  (word_cnt),
    .last_o  (last_beat)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    banks_d = banks_q;
    words_d = words_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    en_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (accept) begin
      en_d   = NUM_BANKS'(onehot(OH_IDX_W'(bank_cnt)));
      addr_d = base_q + ADDR_WIDTH'(word_cnt);
      data_d = s_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            base_d  = base_addr;
            banks_d = num_banks;
            words_d = num_words;
            cnt_clr = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        // abort already forces s_ready low, so no beat can slip through here
        if (abort) begin
          state_d = IDLE;
        end else if (accept && last_beat) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      banks_q <= '0;
      words_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      banks_q <= banks_d;
      words_q <= words_d;
      err_q   <= err_d;
      done_q  <= done_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ram_w_en   = en_q;
  assign ram_w_addr = addr_q;
  assign ram_w_data = data_q;
  assign busy       = (state_q == LOAD);
  assign done       = done_q;
  assign err        = err_q;

endmodule
